// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0,
    OP_ADD = 4'h1,
    OP_AND = 4'h2,
    OP_NOT = 4'h3,
    OP_NOR = 4'h4,
    OP_SUB = 4'h5,
    OP_SLL = 4'h6,
    OP_SRL = 4'h7,
    OP_MUL = 4'h8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for alu_mc; master = requester/consumer, slave = ALU.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       control;
  logic [WIDTH-1:0] input0;
  logic [WIDTH-1:0] input1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_output;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             illegal;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output control, input0, input1, in_valid, out_ready,
    input  in_ready, alu_output, zero, overflow, carry, illegal, out_valid
  );

  modport slave (
    input  control, input0, input1, in_valid, out_ready,
    output in_ready, alu_output, zero, overflow, carry, illegal, out_valid
  );
endinterface

// File: rtl/alu_mc_seq.sv
// Iterative engine: one shift bit or one shift-add step per cycle; o_* are the values after the current step.
// Multiplier datapath only exists when ALU_MC_MUL_EN is defined.
module alu_mc_seq #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_left,
  input  logic [WIDTH-1:0]         i_a,
  input  logic [$clog2(WIDTH):0]   i_cnt,
`ifdef ALU_MC_MUL_EN
  input  logic                     i_mul,
  input  logic [WIDTH-1:0]         i_b,
`endif
  output logic                     o_last,
  output logic [WIDTH-1:0]         o_res,
  output logic                     o_carry,
  output logic                     o_ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic             r_left;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_sh_out;

  always_comb begin
    w_sh_nxt = r_left ? {r_acc[WIDTH-2:0], 1'b0} : {1'b0, r_acc[WIDTH-1:1]};
    w_sh_out = r_left ? r_acc[WIDTH-1] : r_acc[0];
  end

`ifdef ALU_MC_MUL_EN
  logic               r_mul;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;

  // Partial product lives in the upper half; the multiplier drains out of the lower half.
  always_comb begin
    w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
    w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
    o_res      = r_mul ? w_prod_nxt[WIDTH-1:0] : w_sh_nxt;
    o_carry    = r_mul ? 1'b0 : w_sh_out;
    o_ovf      = r_mul ? (|w_prod_nxt[2*WIDTH-1:WIDTH]) : 1'b0;
  end
`else
  always_comb begin
    o_res   = w_sh_nxt;
    o_carry = w_sh_out;
    o_ovf   = 1'b0;
  end
`endif

  assign o_last = (r_cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_acc   <= '0;
`ifdef ALU_MC_MUL_EN
      r_mul   <= 1'b0;
      r_mcand <= '0;
      r_prod  <= '0;
`endif
    end else if (i_start) begin
      r_cnt   <= i_cnt;
      r_left  <= i_left;
      r_acc   <= i_a;
`ifdef ALU_MC_MUL_EN
      r_mul   <= i_mul;
      r_mcand <= i_a;
      r_prod  <= {{WIDTH{1'b0}}, i_b};
`endif
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - CW'(1);
      r_acc   <= w_sh_nxt;
`ifdef ALU_MC_MUL_EN
      r_prod  <= w_prod_nxt;
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle logic/arith, 1+amount for shifts, WIDTH+1 for MUL (ALU_MC_MUL_EN); results held until out_ready.
// in_ready = IDLE, or DONE while the consumer takes the current result (allows back-to-back).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_e           r_state;
  logic             r_vld;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_ovf;
  logic             r_carry;
  logic             r_ill;

  logic             w_accept;
  logic             w_start;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic             w_multi;
  logic             w_left;
  logic [CW-1:0]    w_cnt;
`ifdef ALU_MC_MUL_EN
  logic             w_mul;
`endif
  logic             w_last;
  logic [WIDTH-1:0] w_eng_res;
  logic             w_eng_c;
  logic             w_eng_v;

  assign bus.in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept       = bus.in_valid && bus.in_ready;
  assign w_start        = w_accept && w_multi;
  assign bus.out_valid  = r_vld;
  assign bus.alu_output = r_out;
  assign bus.zero       = r_zero;
  assign bus.overflow   = r_ovf;
  assign bus.carry      = r_carry;
  assign bus.illegal    = r_ill;

  always_comb begin
    w_res   = '0;
    w_sum   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_ill   = 1'b0;
    w_multi = 1'b0;
    w_left  = 1'b0;
    w_cnt   = CW'(bus.input1[SHW-1:0]);
`ifdef ALU_MC_MUL_EN
    w_mul   = 1'b0;
`endif
    case (bus.control)
      OP_MOV: w_res = bus.input0;
      OP_ADD: begin
        w_sum = {1'b0, bus.input0} + {1'b0, bus.input1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.input0[WIDTH-1] == bus.input1[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.input0[WIDTH-1]);
      end
      OP_SUB: begin
        // a + ~b + 1: carry-out high means no borrow
        w_sum = {1'b0, bus.input0} + {1'b0, ~bus.input1} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.input0[WIDTH-1] != bus.input1[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.input0[WIDTH-1]);
      end
      OP_AND: w_res = bus.input0 & bus.input1;
      OP_NOT: w_res = ~bus.input0;
      OP_NOR: w_res = ~(bus.input0 | bus.input1);
      OP_SLL, OP_SRL: begin
        w_left = (bus.control == OP_SLL);
        if (bus.input1[SHW-1:0] == '0) w_res = bus.input0;
        else                           w_multi = 1'b1;
      end
`ifdef ALU_MC_MUL_EN
      OP_MUL: begin
        w_multi = 1'b1;
        w_mul   = 1'b1;
        w_cnt   = CW'(WIDTH);
      end
`endif
      default: w_ill = 1'b1;
    endcase
  end

  alu_mc_seq #(.WIDTH(WIDTH)) u_seq (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_left  (w_left),
    .i_a     (bus.input0),
    .i_cnt   (w_cnt),
`ifdef ALU_MC_MUL_EN
    .i_mul   (w_mul),
    .i_b     (bus.input1),
`endif
    .o_last  (w_last),
    .o_res   (w_eng_res),
    .o_carry (w_eng_c),
    .o_ovf   (w_eng_v)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_vld   <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_accept) begin
      if (w_multi) begin
        r_state <= ST_BUSY;
        r_vld   <= 1'b0;
      end else begin
        r_state <= ST_DONE;
        r_vld   <= 1'b1;
        r_out   <= w_res;
        r_zero  <= !w_ill && (w_res == '0);
        r_ovf   <= w_v;
        r_carry <= w_c;
        r_ill   <= w_ill;
      end
    end else if ((r_state == ST_BUSY) && w_last) begin
      r_state <= ST_DONE;
      r_vld   <= 1'b1;
      r_out   <= w_eng_res;
      r_zero  <= (w_eng_res == '0);
      r_ovf   <= w_eng_v;
      r_carry <= w_eng_c;
      r_ill   <= 1'b0;
    end else if ((r_state == ST_DONE) && bus.out_ready) begin
      r_state <= ST_IDLE;
      r_vld   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=8); MUL expectations follow ALU_MC_MUL_EN.
module tb_alu_mc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc_if #(.WIDTH(8)) bus ();

  alu_mc #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] res;
    logic       z;
    logic       v;
    logic       c;
    logic       ill;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q_exp[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sbv, s, n;
    int unsigned p;
    sa  = $signed(a);
    sbv = $signed(b);
    n   = int'(b[2:0]);
    e.op = op; e.res = 8'h00; e.z = 1'b0; e.v = 1'b0; e.c = 1'b0; e.ill = 1'b0;
    e.lat = 1; e.acc = 0;
    case (op)
      4'h0: e.res = a;
      4'h1: begin
        p = a + b; e.res = p[7:0]; e.c = (p > 255);
        s = sa + sbv; e.v = (s > 127) || (s < -128);
      end
      4'h2: e.res = a & b;
      4'h3: e.res = ~a;
      4'h4: e.res = ~(a | b);
      4'h5: begin
        e.res = a - b; e.c = (a >= b);
        s = sa - sbv; e.v = (s > 127) || (s < -128);
      end
      4'h6: begin e.res = a << n; if (n != 0) e.c = a[8-n]; e.lat = 1 + n; end
      4'h7: begin e.res = a >> n; if (n != 0) e.c = a[n-1]; e.lat = 1 + n; end
`ifdef ALU_MC_MUL_EN
      4'h8: begin p = a * b; e.res = p[7:0]; e.v = ((p >> 8) != 0); e.lat = 9; end
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = !e.ill && (e.res == 8'h00);
    return e;
  endfunction

  // Monitor: latency is measured from the first cycle a result is visible.
  logic fresh = 1'b1;
  int   vld_cyc = 0;
  exp_t m;
  always @(negedge clk) begin
    if (reset || !bus.out_valid) fresh = 1'b1;
    else begin
      if (fresh) begin vld_cyc = cyc; fresh = 1'b0; end
      if (bus.out_ready) begin
        chk("pending", q_exp.size() != 0, 1'b1);
        if (q_exp.size() != 0) begin
          m = q_exp.pop_front();
          chk($sformatf("op%0h_res", m.op), bus.alu_output, m.res);
          chk($sformatf("op%0h_zero", m.op), bus.zero, m.z);
          chk($sformatf("op%0h_ovf", m.op), bus.overflow, m.v);
          chk($sformatf("op%0h_carry", m.op), bus.carry, m.c);
          chk($sformatf("op%0h_ill", m.op), bus.illegal, m.ill);
          chk($sformatf("op%0h_lat", m.op), vld_cyc - m.acc, m.lat);
        end
        fresh = 1'b1;
      end
    end
  end

  // Called and returns at posedge+1; stalls on in_ready release the consumer.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int waited);
    exp_t e;
    int k;
    bus.control = op; bus.input0 = a; bus.input1 = b; bus.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("accept", bus.in_ready, 1'b1);
    if (bus.in_ready) begin
      e = model(op, a, b);
      e.acc = cyc;
      q_exp.push_back(e);
    end
    waited = k;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.control  = 4'($urandom);
    bus.input0   = 8'($urandom);
    bus.input1   = 8'($urandom);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200 && q_exp.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", q_exp.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [3:0] op;
    bus.control = 4'h0; bus.input0 = 8'h00; bus.input1 = 8'h00;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #2;
    chk("rst_vld", bus.out_valid, 1'b0);
    chk("rst_out", bus.alu_output, 8'h00);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_ill", bus.illegal, 1'b0);
    chk("rst_rdy", bus.in_ready, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    issue(4'h1, 8'h7F, 8'h01, w);
    issue(4'h5, 8'h05, 8'h05, w);
    issue(4'h7, 8'hB1, 8'h03, w);
    @(negedge clk); chk("busy_rdy0", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk("busy_rdy1", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    drain();
    issue(4'h8, 8'h10, 8'h11, w);
    drain();
    issue(4'h9, 8'h12, 8'h34, w);
    issue(4'hF, 8'h00, 8'h00, w);
    issue(4'h6, 8'hA5, 8'h00, w);
    issue(4'h7, 8'h81, 8'h08, w);
    issue(4'h4, 8'h0F, 8'hF0, w);
    drain();

    bus.out_ready = 1'b0;
    issue(4'h2, 8'hF0, 8'h3C, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld", bus.out_valid, 1'b1);
      chk("hold_out", bus.alu_output, 8'h30);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    issue(4'h0, 8'h5A, 8'h00, w);
    chk("b2b_wait", w, 0);
    drain();

    issue(4'h6, 8'h01, 8'h07, w);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", bus.out_valid, 1'b0);
    chk("mid_rst_out", bus.alu_output, 8'h00);
    chk("mid_rst_rdy", bus.in_ready, 1'b1);
    q_exp.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    issue(4'h3, 8'h00, 8'h00, w);
    drain();

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 8));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      issue(op, 8'($urandom), 8'($urandom), w);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
